// File: rtl/record_serializer.sv
// record_serializer: buffers 44-bit click records in a small FIFO and emits
// each one as six bytes (MSB first) on a valid/ready byte stream.
// Records arriving while the FIFO is full are dropped, counted (saturating)
// and flagged through the sticky overflow output.
// Optional build macro: RECSER_LOST_FLAG_EN -- when defined, bit 7 of byte0
// marks the first record emitted after any loss; otherwise the pad nibble
// in byte0 is always zero.
module record_serializer #(
  parameter int DEPTH  = 16,
  parameter int LOST_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     rec_valid,
  input  logic [43:0]              rec_data,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [LOST_W-1:0]        lost_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  // Record storage; read combinationally at the pop edge straight into the
  // shift word, which acts as the registered read stage.
  logic [43:0]       mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [LW-1:0]     level_next;

  state_t            state_reg;
  state_t            state_next;
  logic [2:0]        idx_reg;
  logic [2:0]        idx_next;
  logic [47:0]       shift_reg;
  logic [47:0]       shift_next;

  logic              overflow_reg;
  logic [LOST_W-1:0] lost_reg;

  logic              fifo_empty;
  logic              fifo_full;
  logic              handshake;
  logic              last_byte;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [3:0]        pad;

  logic [7:0]        lane [8];

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LW'(DEPTH));
  assign handshake  = (state_reg == S_SEND) && byte_ready;
  assign last_byte  = (idx_reg == 3'd5);

  // A record is accepted when there is room, or when the head leaves on the
  // same edge; clear discards the incoming record without counting it.
  assign wr_en = rec_valid && !clear && (!fifo_full || pop);
  assign drop  = rec_valid && !clear && !wr_en;

`ifdef RECSER_LOST_FLAG_EN
  logic lost_pending_reg;
  logic lost_pending_next;

  // A drop coinciding with a load still marks the loaded record.
  assign pad = {lost_pending_reg | drop, 3'b000};

  always_comb begin
    lost_pending_next = lost_pending_reg;
    if (drop) begin
      lost_pending_next = 1'b1;
    end else if (pop) begin
      lost_pending_next = 1'b0;
    end
  end

  // Pending-loss marker: set by a drop, consumed by the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost_pending_reg <= 1'b0;
    end else if (clear) begin
      lost_pending_reg <= 1'b0;
    end else begin
      lost_pending_reg <= lost_pending_next;
    end
  end
`else
  assign pad = 4'b0000;
`endif

  // Serializer next-state: IDLE pops whenever data waits; SEND walks the six
  // byte lanes and chains straight into the next record without a bubble.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_SEND;
          idx_next   = 3'd0;
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (last_byte) begin
            idx_next = 3'd0;
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  // New shift word on every pop; otherwise the word holds so the presented
  // byte stays stable under backpressure.
  always_comb begin
    shift_next = shift_reg;
    if (pop) begin
      shift_next = {pad, mem[rd_ptr_reg]};
    end
  end

  // Occupancy moves by (write - pop) each edge.
  always_comb begin
    level_next = level_reg;
    case ({wr_en, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Byte lanes of the shift word, lane 0 being the most significant byte;
  // the two unused lanes read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < 6) begin : g_used
        assign lane[gi] = shift_reg[47 - 8*gi -: 8];
      end else begin : g_unused
        assign lane[gi] = 8'h00;
      end
    end
  endgenerate

  assign byte_valid = (state_reg == S_SEND);
  assign byte_data  = byte_valid ? lane[idx_reg] : 8'h00;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;
  assign lost_count = lost_reg;

  // Record storage write port (contents need no reset; pointers gate them).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= rec_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;
    end
  end

  // Serializer state, byte index and shift word; reset abandons any
  // partially sent record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= 3'd0;
      shift_reg <= '0;
    end else if (clear) begin
      state_reg <= S_IDLE;
      idx_reg   <= 3'd0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  // Loss bookkeeping: sticky overflow and a saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      lost_reg     <= '0;
    end else if (clear) begin
      overflow_reg <= 1'b0;
      lost_reg     <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (lost_reg != '1) begin
        lost_reg <= lost_reg + 1'b1;
      end
    end
  end

endmodule
